// File: rtl/mem_rsp.sv
// Multi-cycle memory responder: accepts one request from IDLE, inserts
// WAIT_STATES wait cycles, performs the access, then pulses ack for one cycle.
module mem_rsp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic                accept;
    logic                do_access;

    // Storage is deliberately not reset; contents survive rst_f.
    logic [DATA_W-1:0]   mem [DEPTH];

    assign accept    = (state == ST_IDLE) && req;
    assign do_access = (state == ST_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = ST_WAIT;
            ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ack  = (state == ST_RESP);
        busy = (state != ST_IDLE);
    end

    // Request fields are captured once at accept and used for the whole access.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt     <= 4'd0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= we;
                cnt     <= CNT_INIT;
            end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // rdata only moves on a completed load, so it holds across stores.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            rdata <= '0;
        end else if (do_access && !we_q) begin
            rdata <= mem[addr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (do_access && we_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_rsp.sv
// Directed testbench for mem_rsp: one instance at WAIT_STATES=2, one at 0.
module tb_mem_rsp;

    logic        clk;
    logic        rst_f;

    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;

    logic        req0;
    logic        we0;
    logic [7:0]  addr0;
    logic [31:0] wdata0;
    logic        ack0;
    logic [31:0] rdata0;
    logic        busy0;

    int checks;
    int errors;

    mem_rsp #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(2)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .busy  (busy)
    );

    mem_rsp #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .rst_f (rst_f),
        .req   (req0),
        .we    (we0),
        .addr  (addr0),
        .wdata (wdata0),
        .ack   (ack0),
        .rdata (rdata0),
        .busy  (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one transaction on the WAIT_STATES=2 instance. lat is the number of
    // falling edges after the accept edge before ack is seen (0 = first cycle).
    task automatic run_txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                           input bit scramble, output int lat,
                           output logic [31:0] rd_at_ack, output logic busy_first,
                           output logic ack_after);
        lat        = -1;
        rd_at_ack  = '0;
        busy_first = 1'b0;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) busy_first = busy;
            if (ack) begin
                lat       = i;
                rd_at_ack = rdata;
                break;
            end
            if (scramble) begin
                addr  = addr ^ 8'h5A;
                wdata = ~wdata;
                we    = ~we;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL txn_timeout: ack not seen within 40 cycles (addr %h)", a);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        ack_after = ack;
    endtask

    task automatic test_reset();
        dut.mem[8'h05]  = 32'hDEAD_BEEF;
        dut.mem[8'h40]  = 32'h4040_4040;
        dut.mem[8'h7A]  = 32'h7A7A_7A7A;
        dut0.mem[8'h03] = 32'h3333_3333;
        dut0.mem[8'h04] = 32'h4444_4444;
        #2;
        rst_f = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ack: got %b expected 0", ack);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", rdata);
        end
        @(negedge clk);
        rst_f = 1'b1;
        checks++;
        if (dut.mem[8'h05] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL reset_mem_kept: got %h expected deadbeef", dut.mem[8'h05]);
        end
    endtask

    task automatic test_load_latency();
        int          lat;
        logic [31:0] rd;
        logic        bf;
        logic        aa;
        run_txn(1'b0, 8'h05, 32'h0, 1'b0, lat, rd, bf, aa);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("[TB] FAIL load_latency: got %0d expected 3", lat);
        end
        checks++;
        if (bf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_busy: got %b expected 1", bf);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL load_rdata: got %h expected deadbeef", rd);
        end
        checks++;
        if (aa !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_ack_width: ack still %b after one cycle, expected 0", aa);
        end
        @(negedge clk);
        checks++;
        if (rdata !== 32'hDEAD_BEEF || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_rdata_hold: got rdata %h busy %b expected deadbeef 0", rdata, busy);
        end
    endtask

    task automatic test_store_load();
        int          lat;
        logic [31:0] rd;
        logic        bf;
        logic        aa;
        run_txn(1'b1, 8'hFF, 32'h0000_1234, 1'b0, lat, rd, bf, aa);
        checks++;
        if (lat != 3 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL store_rdata_kept: got lat %0d rdata %h expected 3 deadbeef", lat, rd);
        end
        run_txn(1'b0, 8'hFF, 32'h0, 1'b0, lat, rd, bf, aa);
        checks++;
        if (rd !== 32'h0000_1234) begin
            errors++;
            $display("[TB] FAIL raw_rdata: got %h expected 00001234", rd);
        end
    endtask

    task automatic test_input_stability();
        int          lat;
        logic [31:0] rd;
        logic        bf;
        logic        aa;
        run_txn(1'b1, 8'h20, 32'hA5A5_0001, 1'b1, lat, rd, bf, aa);
        run_txn(1'b0, 8'h20, 32'h0, 1'b1, lat, rd, bf, aa);
        checks++;
        if (rd !== 32'hA5A5_0001) begin
            errors++;
            $display("[TB] FAIL stable_store_load: got %h expected a5a50001", rd);
        end
        run_txn(1'b0, 8'h7A, 32'h0, 1'b0, lat, rd, bf, aa);
        checks++;
        if (rd !== 32'h7A7A_7A7A) begin
            errors++;
            $display("[TB] FAIL stable_no_stray_write: got %h expected 7a7a7a7a", rd);
        end
    endtask

    task automatic test_reset_in_wait();
        int          lat;
        logic [31:0] rd;
        logic        bf;
        logic        aa;
        logic        saw_ack;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 8'h40;
        wdata = 32'hBAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstwait_in_wait: got busy %b ack %b expected 1 0", busy, ack);
        end
        rst_f = 1'b0;
        #1;
        req = 1'b0;
        we  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstwait_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        rst_f = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstwait_no_ack: got ack %b expected 0", saw_ack);
        end
        run_txn(1'b0, 8'h40, 32'h0, 1'b0, lat, rd, bf, aa);
        checks++;
        if (rd !== 32'h4040_4040 || lat != 3) begin
            errors++;
            $display("[TB] FAIL rstwait_after: got rdata %h lat %0d expected 40404040 3", rd, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic gap_seen;
        req0   = 1'b1;
        we0    = 1'b0;
        addr0  = 8'h03;
        wdata0 = 32'h0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || ack0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_first_wait: got busy %b ack %b expected 1 0", busy0, ack0);
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || rdata0 !== 32'h3333_3333) begin
            errors++;
            $display("[TB] FAIL b2b_first_ack: got ack %b rdata %h expected 1 33333333", ack0, rdata0);
        end
        addr0 = 8'h04;
        @(negedge clk);
        gap_seen = (busy0 === 1'b0) && (ack0 === 1'b0);
        checks++;
        if (!gap_seen) begin
            errors++;
            $display("[TB] FAIL b2b_idle_gap: got busy %b ack %b expected 0 0", busy0, ack0);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || ack0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second_accept: got busy %b ack %b expected 1 0", busy0, ack0);
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || rdata0 !== 32'h4444_4444) begin
            errors++;
            $display("[TB] FAIL b2b_second_ack: got ack %b rdata %h expected 1 44444444", ack0, rdata0);
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || ack0 !== 1'b0 || rdata0 !== 32'h4444_4444) begin
            errors++;
            $display("[TB] FAIL b2b_end: got busy %b ack %b rdata %h expected 0 0 44444444",
                     busy0, ack0, rdata0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_f  = 1'b1;
        req    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        req0   = 1'b0;
        we0    = 1'b0;
        addr0  = '0;
        wdata0 = '0;
        test_reset();
        test_load_latency();
        test_store_load();
        test_input_stability();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
